ofdm_tx_cp_packer: RTL and testbench
====================================

// Module: ofdm_tx_cp_packer
// PURPOSE
//  OFDM TX stage directly upstream of the AD9764 DAC AXIS slave. Buffers one IFFT symbol of signed
//  samples in a ping-pong RAM, prepends the cyclic prefix, converts to 14-bit offset binary and packs
//  two samples per 32-bit AXIS word ({odd,even}, even in [13:0], odd in [29:16], bits 31:30/15:14 zero).
// PARAMETERS
//  NFFT      64  samples per symbol; power of 2, >=8
//  CP_LEN    16  cyclic-prefix samples; even, 2..NFFT
//  IN_W      16  input sample width, two's complement
// PORTS
//  s00_axis_aclk     in   1      single clock, all logic
//  s00_axis_areset   in   1      asynchronous, active-high reset
//  enable            in   1      gates start of a new output symbol (control-register bit)
//  s00_axis_tdata    in   IN_W   IFFT sample
//  s00_axis_tvalid   in   1      input valid
//  s00_axis_tready   out  1      input ready
//  s00_axis_tlast    in   1      last sample of symbol
//  m00_axis_tdata    out  32     packed sample pair to DAC block
//  m00_axis_tvalid   out  1      output valid
//  m00_axis_tready   in   1      output ready
//  m00_axis_tlast    out  1      last word of symbol (incl. CP)
//  frame_err         out  1      sticky; tlast/length mismatch seen; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0 except s00_axis_tready=1 one cycle after release; both banks empty, wr/rd bank=0.
//  Input: sample accepted on tvalid&tready; written to wr bank at wr_cnt. tready=!full[wr_bank].
//   wr_cnt==NFFT-1 accepted: bank full[wr]=1, wr_bank toggles, wr_cnt=0; tlast low there -> frame_err=1.
//   tlast at wr_cnt<NFFT-1: symbol discarded (wr_cnt=0, bank not marked), frame_err=1.
//  Conversion: out14 = {~s[IN_W-1], s[IN_W-2:IN_W-14]} (truncate, MSB invert); no rounding.
//  Output FSM IDLE/CP/BODY, rd_addr steps by 2 per word:
//   IDLE: full[rd]&enable -> CP, load word at rd_addr=NFFT-CP_LEN.
//   CP:   emit CP_LEN/2 words (addr NFFT-CP_LEN..NFFT-1) -> BODY at addr 0.
//   BODY: emit NFFT/2 words; last word has tlast=1; on its handshake full[rd]=0, rd_bank toggles,
//         -> CP if full[other]&enable else IDLE.
//  Output register: advances only on tvalid&tready; tdata/tlast stable while tvalid&!tready.
//  Latency: last input sample accepted at edge E (FSM IDLE, enable=1) -> tvalid=1 after edge E+1.
//  Back-to-back symbols: no idle cycle between tlast word and next CP word if next bank full.
//  Simultaneous last-input and bank-free on same edge: both take effect; tready stays correct.
//  enable dropped mid-symbol: current symbol completes; no new symbol starts.
//  Reset mid-operation: immediate clear, partial symbol lost, tvalid=0 asynchronously.
// CONFIGURATION
//  OFDM_TX_UNDERRUN_CNT_EN defined: adds output underrun_cnt[15:0], saturating count of cycles in
//   IDLE with enable=1 and m00_axis_tready=1 after first symbol sent; reset to 0.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package ofdm_tx_pkg: FSM state encoding (IDLE/CP/BODY), to_offset14() function, default NFFT/CP_LEN.
//  Sub-module ofdm_tx_pingpong_ram: 2 x NFFT x IN_W, 1 write port, 2-sample read (addr, addr+1),
//   bank select inputs; top holds counters, FSM, full flags, packer, output register.
// TESTING (NFFT=64, CP_LEN=16, input s=4*i, i=0..63, tlast at i=63; 40 words/symbol)
//  1 Reset then release -> all outputs 0, s00_axis_tready=1, frame_err=0.
//  2 One symbol, tready=1 -> word0=0x2031_2030, word7=0x203F_203E, word8=0x2001_2000,
//    word39=0x203F_203E with tlast=1; tvalid high after edge E+1.
//  3 m00_axis_tready pattern 1,0,1,0... -> same 40 words, no drop/dup, tdata stable when stalled.
//  4 Three symbols streamed, m00_axis_tready=0 -> s00_axis_tready=0 after 128 samples; release ->
//    120 words, tlast every 40th, third symbol accepted once bank 0 frees.
//  5 tlast at i=10 -> frame_err=1, no output; next good symbol output as in test 2.
//  6 Reset asserted at word 20 -> tvalid=0 at once; after release a new symbol outputs from word0.

Source files
------------

// File: rtl/ofdm_tx_pkg.sv
// Shared types and helpers for the OFDM TX cyclic-prefix packer.
package ofdm_tx_pkg;

  localparam int NFFT_DEF   = 64;
  localparam int CP_LEN_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CP   = 2'd1,
    ST_BODY = 2'd2
  } tx_state_e;

  // Keep the top 14 bits of a w-bit two's-complement sample and flip the MSB (offset binary).
  function automatic logic [13:0] to_offset14(input logic [31:0] s, input int w);
    return {~s[w-1], s[w-2 -: 13]};
  endfunction

endpackage

// File: rtl/ofdm_tx_pingpong_ram.sv
// Two-bank symbol buffer: one write port, combinational read of an even/odd sample pair.
module ofdm_tx_pingpong_ram #(
  parameter int NFFT = 64,
  parameter int IN_W = 16
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic                    wr_bank,
  input  logic [$clog2(NFFT)-1:0] wr_addr,
  input  logic [IN_W-1:0]         wr_dat,
  input  logic                    rd_bank,
  input  logic [$clog2(NFFT)-1:0] rd_addr,
  output logic [IN_W-1:0]         rd_dat0,
  output logic [IN_W-1:0]         rd_dat1
);

  localparam int AW = $clog2(NFFT);

  logic [IN_W-1:0] mem_q [2*NFFT];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[{wr_bank, wr_addr}] <= wr_dat;
  end

  // Read addresses are always even; the odd partner sits at addr|1.
  assign rd_dat0 = mem_q[{rd_bank, rd_addr}];
  assign rd_dat1 = mem_q[{rd_bank, rd_addr | AW'(1)}];

endmodule

// File: rtl/ofdm_tx_cp_packer.sv
// OFDM TX: ping-pong symbol buffer, cyclic-prefix insertion, 14-bit offset-binary pair packing to AXIS.
// Optional OFDM_TX_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module ofdm_tx_cp_packer
  import ofdm_tx_pkg::*;
#(
  parameter int NFFT   = NFFT_DEF,
  parameter int CP_LEN = CP_LEN_DEF,
  parameter int IN_W   = 16
) (
  input  logic            s00_axis_aclk,
  input  logic            s00_axis_areset,
  input  logic            enable,
  input  logic [IN_W-1:0] s00_axis_tdata,
  input  logic            s00_axis_tvalid,
  output logic            s00_axis_tready,
  input  logic            s00_axis_tlast,
  output logic [31:0]     m00_axis_tdata,
  output logic            m00_axis_tvalid,
  input  logic            m00_axis_tready,
  output logic            m00_axis_tlast,
  output logic            frame_err
`ifdef OFDM_TX_UNDERRUN_CNT_EN
  ,output logic [15:0]    underrun_cnt
`endif
);

  localparam int AW = $clog2(NFFT);
  localparam logic [AW-1:0] CP_START  = AW'(NFFT - CP_LEN);
  localparam logic [AW-1:0] LAST_PAIR = AW'(NFFT - 2);
  localparam logic [AW-1:0] LAST_WR   = AW'(NFFT - 1);

  logic [AW-1:0] wr_cnt_q, wr_cnt_d, rd_addr_q, rd_addr_d;
  logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;
  logic          frame_err_q, frame_err_d;
  tx_state_e     state_q, state_d, ld_state;
  logic          out_vld_q, out_vld_d, out_last_q, out_last_d;
  logic [31:0]   out_dat_q, out_dat_d;

  logic            s_acc, out_hs, load, ld_bank;
  logic [AW-1:0]   ld_addr;
  logic [IN_W-1:0] rd_dat0, rd_dat1;

  assign s00_axis_tready = ~full_q[wr_bank_q];
  assign s_acc           = s00_axis_tvalid & s00_axis_tready;
  assign out_hs          = out_vld_q & m00_axis_tready;

  ofdm_tx_pingpong_ram #(.NFFT(NFFT), .IN_W(IN_W)) u_ram (
    .clk     (s00_axis_aclk),
    .wr_en   (s_acc),
    .wr_bank (wr_bank_q),
    .wr_addr (wr_cnt_q),
    .wr_dat  (s00_axis_tdata),
    .rd_bank (ld_bank),
    .rd_addr (ld_addr),
    .rd_dat0 (rd_dat0),
    .rd_dat1 (rd_dat1)
  );

  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    full_d      = full_q;
    frame_err_d = frame_err_q;
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    rd_bank_d   = rd_bank_q;
    out_vld_d   = out_vld_q;
    out_last_d  = out_last_q;
    out_dat_d   = out_dat_q;
    load        = 1'b0;
    ld_state    = state_q;
    ld_addr     = rd_addr_q;
    ld_bank     = rd_bank_q;

    if (s_acc) begin
      if (wr_cnt_q == LAST_WR) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
        if (!s00_axis_tlast) frame_err_d = 1'b1;
      end else if (s00_axis_tlast) begin
        wr_cnt_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + AW'(1);
      end
    end

    // The output register holds the word at rd_addr_q; a handshake fetches the following pair.
    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_bank_q] && enable) begin
          load     = 1'b1;
          ld_state = ST_CP;
          ld_addr  = CP_START;
        end
      end
      ST_CP: begin
        if (out_hs) begin
          load = 1'b1;
          if (rd_addr_q == LAST_PAIR) begin
            ld_state = ST_BODY;
            ld_addr  = '0;
          end else begin
            ld_addr = rd_addr_q + AW'(2);
          end
        end
      end
      ST_BODY: begin
        if (out_hs) begin
          if (rd_addr_q == LAST_PAIR) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            ld_bank           = ~rd_bank_q;
            if (full_q[~rd_bank_q] && enable) begin
              load     = 1'b1;
              ld_state = ST_CP;
              ld_addr  = CP_START;
            end else begin
              state_d    = ST_IDLE;
              out_vld_d  = 1'b0;
              out_last_d = 1'b0;
            end
          end else begin
            load    = 1'b1;
            ld_addr = rd_addr_q + AW'(2);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d    = ld_state;
      rd_addr_d  = ld_addr;
      out_vld_d  = 1'b1;
      out_last_d = (ld_state == ST_BODY) && (ld_addr == LAST_PAIR);
      out_dat_d  = {2'b00, to_offset14(32'(signed'(rd_dat1)), IN_W),
                    2'b00, to_offset14(32'(signed'(rd_dat0)), IN_W)};
    end
  end

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_addr_q   <= '0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      frame_err_q <= 1'b0;
      state_q     <= ST_IDLE;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_dat_q   <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_addr_q   <= rd_addr_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      frame_err_q <= frame_err_d;
      state_q     <= state_d;
      out_vld_q   <= out_vld_d;
      out_last_q  <= out_last_d;
      out_dat_q   <= out_dat_d;
    end
  end

  assign m00_axis_tdata  = out_dat_q;
  assign m00_axis_tvalid = out_vld_q;
  assign m00_axis_tlast  = out_last_q;
  assign frame_err       = frame_err_q;

`ifdef OFDM_TX_UNDERRUN_CNT_EN
  logic        sent_q, sent_d;
  logic [15:0] urun_q, urun_d;

  always_comb begin
    sent_d = sent_q | (out_hs & out_last_q);
    urun_d = urun_q;
    if (sent_q && (state_q == ST_IDLE) && enable && m00_axis_tready && (urun_q != 16'hFFFF))
      urun_d = urun_q + 16'd1;
  end

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      sent_q <= 1'b0;
      urun_q <= '0;
    end else begin
      sent_q <= sent_d;
      urun_q <= urun_d;
    end
  end

  assign underrun_cnt = urun_q;
`endif

endmodule

// File: tb/tb_ofdm_tx_cp_packer.sv
// Directed bench for ofdm_tx_cp_packer (NFFT=64, CP_LEN=16, samples s=4*i).
module tb_ofdm_tx_cp_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] s_dat = '0;
  logic        s_vld = 1'b0;
  logic        s_rdy;
  logic        s_last = 1'b0;
  logic [31:0] m_dat;
  logic        m_vld;
  logic        m_rdy = 1'b0;
  logic        m_last;
  logic        frame_err;

  ofdm_tx_cp_packer dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .enable          (enable),
    .s00_axis_tdata  (s_dat),
    .s00_axis_tvalid (s_vld),
    .s00_axis_tready (s_rdy),
    .s00_axis_tlast  (s_last),
    .m00_axis_tdata  (m_dat),
    .m00_axis_tvalid (m_vld),
    .m00_axis_tready (m_rdy),
    .m00_axis_tlast  (m_last),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fail_cnt = 0;
  int cyc      = 0;
  int rdy_mode = 1;  // 0: held low, 1: held high, 2: alternating

  logic [16:0] src[$];
  logic [31:0] rx_dat[$];
  logic        rx_last[$];
  logic        stall_pend = 1'b0;
  logic [32:0] stall_word = '0;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample s=4*i gives offset14 = 0x2000 + i; CP words cover i=48..63, body words i=0..63.
  function automatic logic [31:0] exp_word(input int k);
    int a;
    a = (k < 8) ? 48 + 2 * k : 2 * (k - 8);
    return {16'h2000 | 16'(a + 1), 16'h2000 | 16'(a)};
  endfunction

  task automatic push_symbol(input int last_at);
    for (int i = 0; i <= last_at; i++) src.push_back({(i == last_at), 16'(4 * i)});
  endtask

  // One cycle: drive at negedge, record handshakes, advance to next negedge.
  task automatic tick();
    if (src.size() > 0) begin
      s_vld = 1'b1; s_dat = src[0][15:0]; s_last = src[0][16];
    end else begin
      s_vld = 1'b0; s_dat = '0; s_last = 1'b0;
    end
    m_rdy = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? cyc[0] : 1'b0;
    #1;
    if (stall_pend) check("stall_stable", {m_vld, m_last, m_dat}, stall_word);
    stall_pend = m_vld && !m_rdy;
    stall_word = {1'b1, m_last, m_dat};
    if (m_vld && m_rdy) begin rx_dat.push_back(m_dat); rx_last.push_back(m_last); end
    if (s_vld && s_rdy) void'(src.pop_front());
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int n, input int budget);
    int t;
    t = 0;
    while (rx_dat.size() < n && t < budget) begin tick(); t++; end
    check("drain_count", 33'(rx_dat.size()), 33'(n));
  endtask

  task automatic cmp_words(input string tag, input int nsym);
    for (int k = 0; k < 40 * nsym && k < rx_dat.size(); k++) begin
      check($sformatf("%s_w%0d", tag, k), {1'b0, rx_dat[k]}, {1'b0, exp_word(k % 40)});
      check($sformatf("%s_l%0d", tag, k), 33'(rx_last[k]), 33'((k % 40) == 39));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; s_vld = 1'b0; m_rdy = 1'b0;
    src.delete(); rx_dat.delete(); rx_last.delete(); stall_pend = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int t;
    // 1: reset state
    do_reset();
    check("rst_tdata", {1'b0, m_dat}, 33'h0);
    check("rst_tvalid", 33'(m_vld), 33'd0);
    check("rst_tlast", 33'(m_last), 33'd0);
    check("rst_tready", 33'(s_rdy), 33'd1);
    check("rst_frame_err", 33'(frame_err), 33'd0);

    // 2: single symbol, latency and key words
    rdy_mode = 1;
    push_symbol(63);
    while (src.size() > 0 && cyc < 2000) tick();
    check("lat_after_E", 33'(m_vld), 33'd0);
    tick();
    check("lat_after_E1", 33'(m_vld), 33'd1);
    check("t2_word0_direct", {1'b0, m_dat}, 33'h0_2031_2030);
    drain(40, 200);
    if (rx_dat.size() >= 40) begin
      check("t2_word7", {1'b0, rx_dat[7]}, 33'h0_203F_203E);
      check("t2_word8", {1'b0, rx_dat[8]}, 33'h0_2001_2000);
      check("t2_word39", {rx_last[39], rx_dat[39]}, 33'h1_203F_203E);
    end
    cmp_words("t2", 1);
    tick(); tick();
    check("t2_idle_after", 33'(m_vld), 33'd0);

    // 3: alternating output ready
    rx_dat.delete(); rx_last.delete();
    rdy_mode = 2;
    push_symbol(63);
    drain(40, 600);
    cmp_words("t3", 1);

    // 4: three symbols with output blocked, then released
    rx_dat.delete(); rx_last.delete();
    rdy_mode = 0;
    push_symbol(63); push_symbol(63); push_symbol(63);
    t = 0;
    while (src.size() > 64 && t < 500) begin tick(); t++; end
    repeat (5) tick();
    check("t4_accepted", 33'(src.size()), 33'd64);
    check("t4_tready_low", 33'(s_rdy), 33'd0);
    rdy_mode = 1;
    drain(120, 1000);
    cmp_words("t4", 3);
    check("t4_src_empty", 33'(src.size()), 33'd0);

    // 5: short symbol flags frame_err, next good symbol still correct
    do_reset();
    rdy_mode = 1;
    check("t5_err_before", 33'(frame_err), 33'd0);
    push_symbol(10);
    repeat (20) tick();
    check("t5_frame_err", 33'(frame_err), 33'd1);
    check("t5_no_output", 33'(rx_dat.size()), 33'd0);
    push_symbol(63);
    drain(40, 300);
    cmp_words("t5", 1);
    check("t5_err_sticky", 33'(frame_err), 33'd1);

    // 6: reset in the middle of a symbol
    do_reset();
    rdy_mode = 1;
    push_symbol(63);
    drain(20, 300);
    rst = 1'b1;
    #1;
    check("t6_tvalid_async", 33'(m_vld), 33'd0);
    @(negedge clk);
    rst = 1'b0;
    src.delete(); rx_dat.delete(); rx_last.delete(); stall_pend = 1'b0;
    @(negedge clk);
    check("t6_tready", 33'(s_rdy), 33'd1);
    push_symbol(63);
    drain(40, 300);
    cmp_words("t6", 1);

    // 7: enable low holds a full bank back
    rx_dat.delete(); rx_last.delete();
    repeat (3) tick();
    enable = 1'b0;
    push_symbol(63);
    repeat (80) tick();
    check("t7_held_tvalid", 33'(m_vld), 33'd0);
    enable = 1'b1;
    drain(40, 300);
    cmp_words("t7", 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
